// File: rtl/cal_set_ctrl.sv
// Date/time setting controller: free-running 1 ms tick for the debouncers and a
// field-select editor that captures the running calendar, edits it and hands it back.
//
// state  | meaning
// RUN    | calendar counting; only MODE is acted on (capture and start editing)
// S_YEAR | editing year 0..99
// S_MON  | editing month 1..12
// S_DAY  | editing day 1..maxday (clamped on entry from S_MON)
// S_HOUR | editing hour 0..23
// S_MIN  | editing minute 0..59; MODE here returns to RUN with a LOAD pulse
module cal_set_ctrl #(
    parameter int CLK_PER_MS = 50000,
    parameter int TIMEOUT_MS = 10000
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST,
    output logic       MS_F,
    input  logic       KEY_MODE,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic [6:0] CUR_YEAR,
    input  logic [3:0] CUR_MON,
    input  logic [4:0] CUR_DAY,
    input  logic [4:0] CUR_HOUR,
    input  logic [5:0] CUR_MIN,
    output logic [6:0] SET_YEAR,
    output logic [3:0] SET_MON,
    output logic [4:0] SET_DAY,
    output logic [4:0] SET_HOUR,
    output logic [5:0] SET_MIN,
    output logic       LOAD,
    output logic       SET_MODE,
    output logic [2:0] FIELD
);

    localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_MS - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        S_YEAR = 3'd1,
        S_MON  = 3'd2,
        S_DAY  = 3'd3,
        S_HOUR = 3'd4,
        S_MIN  = 3'd5
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          ms_f_q;
    logic [TW-1:0] to_q;
    logic [6:0]    yr_q;
    logic [3:0]    mon_q;
    logic [4:0]    day_q;
    logic [4:0]    hr_q;
    logic [5:0]    min_q;
    logic          load_q;
    logic          set_mode_q;

    logic [4:0] maxday;
    logic [6:0] yr_inc, yr_dec;
    logic [3:0] mon_inc, mon_dec;
    logic [4:0] day_inc, day_dec;
    logic [4:0] hr_inc, hr_dec;
    logic [5:0] min_inc, min_dec;
    logic       step_up, step_dn;

    function automatic logic [4:0] max_day(input logic [3:0] mon, input logic [6:0] yr);
        logic [4:0] md;
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: md = 5'd30;
            4'd2:                    md = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 md = 5'd31;
        endcase
        return md;
    endfunction

    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            presc_q <= '0;
            ms_f_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ms_f_q  <= (presc_d == PRESC_LAST);
        end
    end

    // Wrapped neighbours of every field; the FSM only picks the one for the active field.
    always_comb begin
        maxday  = max_day(mon_q, yr_q);
        yr_inc  = (yr_q >= 7'd99) ? 7'd0 : yr_q + 7'd1;
        yr_dec  = (yr_q == 7'd0) ? 7'd99 : yr_q - 7'd1;
        mon_inc = (mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1;
        mon_dec = (mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1;
        day_inc = (day_q >= maxday) ? 5'd1 : day_q + 5'd1;
        day_dec = (day_q <= 5'd1) ? maxday : day_q - 5'd1;
        hr_inc  = (hr_q >= 5'd23) ? 5'd0 : hr_q + 5'd1;
        hr_dec  = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
        min_inc = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
        min_dec = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        step_up = KEY_UP & ~KEY_DOWN;
        step_dn = KEY_DOWN & ~KEY_UP;
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= RUN;
            to_q       <= '0;
            yr_q       <= '0;
            mon_q      <= '0;
            day_q      <= '0;
            hr_q       <= '0;
            min_q      <= '0;
            load_q     <= 1'b0;
            set_mode_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (state_q == RUN) begin
                if (KEY_MODE) begin
                    yr_q       <= CUR_YEAR;
                    mon_q      <= CUR_MON;
                    day_q      <= CUR_DAY;
                    hr_q       <= CUR_HOUR;
                    min_q      <= CUR_MIN;
                    to_q       <= '0;
                    set_mode_q <= 1'b1;
                    state_q    <= S_YEAR;
                end
            end else if (KEY_MODE) begin
                to_q <= '0;
                case (state_q)
                    S_YEAR: state_q <= S_MON;
                    S_MON: begin
                        state_q <= S_DAY;
                        if (day_q > maxday) day_q <= maxday;
                    end
                    S_DAY:  state_q <= S_HOUR;
                    S_HOUR: state_q <= S_MIN;
                    S_MIN: begin
                        state_q    <= RUN;
                        set_mode_q <= 1'b0;
                        load_q     <= 1'b1;
                    end
                    default: begin
                        state_q    <= RUN;
                        set_mode_q <= 1'b0;
                    end
                endcase
            end else if (KEY_UP || KEY_DOWN) begin
                // UP and DOWN together still count as activity but leave the field alone.
                to_q <= '0;
                if (step_up) begin
                    case (state_q)
                        S_YEAR:  yr_q  <= yr_inc;
                        S_MON:   mon_q <= mon_inc;
                        S_DAY:   day_q <= day_inc;
                        S_HOUR:  hr_q  <= hr_inc;
                        S_MIN:   min_q <= min_inc;
                        default: ;
                    endcase
                end else if (step_dn) begin
                    case (state_q)
                        S_YEAR:  yr_q  <= yr_dec;
                        S_MON:   mon_q <= mon_dec;
                        S_DAY:   day_q <= day_dec;
                        S_HOUR:  hr_q  <= hr_dec;
                        S_MIN:   min_q <= min_dec;
                        default: ;
                    endcase
                end
            end else if (ms_f_q) begin
                if (to_q == TO_LAST) begin
                    to_q       <= '0;
                    set_mode_q <= 1'b0;
                    state_q    <= RUN;
                end else begin
                    to_q <= to_q + TW'(1);
                end
            end
        end
    end

    assign MS_F     = ms_f_q;
    assign LOAD     = load_q;
    assign SET_MODE = set_mode_q;
    assign FIELD    = state_q;
    assign SET_YEAR = yr_q;
    assign SET_MON  = mon_q;
    assign SET_DAY  = day_q;
    assign SET_HOUR = hr_q;
    assign SET_MIN  = min_q;

endmodule

// File: doc/cal_set_ctrl.md
Name: cal_set_ctrl

Overview:
Time/date setting controller for the calendar. It generates the shared 1 ms tick that paces the push-button debouncers and consumes their one-cycle MODE/UP/DOWN pulses. A field-select FSM edits a captured copy of the running date/time, then hands the edited values back to the calendar counters with a single load pulse. The block sits between the debouncer instances and the calendar/timekeeping core.

Parameters:
CLK_PER_MS, 50000, SYS_CLK cycles per MS_F tick (≥2)
TIMEOUT_MS, 10000, idle ms in an edit state before abort to RUN

Ports:
SYS_CLK  in  1  system clock
SYS_RST  in  1  asynchronous, active-high reset
MS_F  out  1  one-cycle tick every CLK_PER_MS cycles; feeds the debouncers
KEY_MODE  in  1  debounced one-cycle pulse
KEY_UP  in  1  debounced one-cycle pulse
KEY_DOWN  in  1  debounced one-cycle pulse
CUR_YEAR  in  7  running year 0..99 (2000..2099)
CUR_MON  in  4  running month 1..12
CUR_DAY  in  5  running day 1..31
CUR_HOUR  in  5  running hour 0..23
CUR_MIN  in  6  running minute 0..59
SET_YEAR/SET_MON/SET_DAY/SET_HOUR/SET_MIN  out  7/4/5/5/6  edited values; valid while LOAD=1
LOAD  out  1  one-cycle pulse: calendar loads SET_*
SET_MODE  out  1  high while editing; calendar holds its count
FIELD  out  3  0=RUN, 1=year, 2=month, 3=day, 4=hour, 5=minute (display blink select)

Behaviour:
- Reset (async): state RUN, prescaler 0, timeout counter 0, all outputs 0, all edit registers 0.
- Prescaler: counter 0..CLK_PER_MS-1 that wraps. MS_F=1 exactly in the cycle the counter equals CLK_PER_MS-1. Free-running in all states.
- FSM states RUN, S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN. FIELD encodes the state. All outputs are registered.
- RUN + KEY_MODE: capture all CUR_* into the edit registers, go to S_YEAR, SET_MODE=1 from the next cycle. KEY_UP and KEY_DOWN are ignored in RUN.
- Edit state + KEY_MODE: advance S_YEAR→S_MON→S_DAY→S_HOUR→S_MIN.
- S_MIN + KEY_MODE: go to RUN. LOAD=1 and SET_MODE=0 in the same following cycle.
- SET_* always reflect the edit registers and are held after LOAD until the next capture.
- Edit state + KEY_UP: active field +1, with wrap-around:
  - year 99→0
  - month 12→1
  - day maxday→1
  - hour 23→0
  - minute 59→0
- Edit state + KEY_DOWN: active field −1, with the reverse wrap (year 0→99, month 1→12, day 1→maxday, hour 0→23, minute 0→59).
- maxday: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; month 2 gives 29 when year[1:0]==0, else 28.
- Transition S_MON→S_DAY: if edit day > maxday(edit month, edit year), clamp day to maxday.
- Simultaneous pulses:
  - KEY_MODE has priority; UP/DOWN are ignored that cycle.
  - KEY_UP together with KEY_DOWN (without MODE): no change.
- Timeout: a counter of MS_F ticks runs in edit states and clears on any key pulse and on entry to an edit state. When it reaches TIMEOUT_MS: go to RUN, SET_MODE=0, no LOAD, edits discarded.
- Reset mid-edit: immediate return to RUN, no LOAD. The calendar keeps its own count.
- Latency: each key pulse takes effect on the edit register/state at the next SYS_CLK edge.

Test Plan:
- CLK_PER_MS=4, reset released: MS_F high on cycles 3,7,11,…; all outputs 0 during reset. Assert reset mid-count → prescaler restarts at 0.
- CUR=24/02/29 13:45, MODE → FIELD=1, SET_MODE=1. UP ×75 → year 99; UP → year 0. Then MODE, DOWN → month 1; DOWN → month 12.
- Capture day 31 month 1 year 23; set month 2 (DOWN from 1 wraps to 12, so use UP). MODE into S_DAY → day clamps to 28; with year 24 → 29. UP at 29 (yr 24) → day 1.
- Full pass: five MODE pulses after entry with hour UP, minute DOWN (0→59) → one-cycle LOAD with SET_HOUR/SET_MIN as edited, SET_MODE falls the same cycle, FIELD=0.
- KEY_UP+KEY_DOWN same cycle → field unchanged. KEY_MODE+KEY_UP same cycle in S_HOUR → S_MIN, hour unchanged.
- TIMEOUT_MS=3, CLK_PER_MS=4: enter edit, no keys → after 3 MS_F ticks back to RUN, LOAD never pulses. A key pulse at tick 2 restarts the count.
